// File: rtl/tc_mm_result_wb_pkg.sv
// Shared defaults and helpers for the matrix-result writeback collector.
// Field widths here fix the layout of a queued writeback entry.
package tc_mm_result_wb_pkg;

    localparam int TC_MATRIX_BUS_WIDTH = 512;
    localparam int TC_DEPTH_WARP       = 3;
    localparam int TC_WB_BEATS         = 4;
    localparam int TC_WB_FIFO_DEPTH    = 2;

    localparam int FFLAGS_W  = 5;
    localparam int REG_IDX_W = 8;

    // Destination register wraps modulo 256, so FE + 3 lands on 01.
    function automatic logic [REG_IDX_W-1:0] wb_dest_idx(
        input logic [REG_IDX_W-1:0] base,
        input logic [REG_IDX_W-1:0] beat
    );
        return base + beat;
    endfunction

endpackage

// File: rtl/tc_sync_fifo.sv
// Generic synchronous FIFO with a registered head entry and registered occupancy.
// DEPTH must be a power of two so the pointers wrap on their own.
module tc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_next;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] head_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = head_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_next = rd_ptr + AW'(1);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            head_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_next;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
            // With one entry left, the next head (if any) is the word being pushed now.
            if (do_pop) begin
                if (count_q != CNT_ONE) begin
                    head_q <= mem[rd_next];
                end else if (do_push) begin
                    head_q <= din;
                end
            end else if (do_push && empty) begin
                head_q <= din;
            end
        end
    end

endmodule

// File: rtl/tc_mm_result_wb.sv
// Collects the result beats of one matrix transaction, tags each with register/warp
// and cumulative fflags, and queues them for the register-file writeback port.
module tc_mm_result_wb
    import tc_mm_result_wb_pkg::*;
#(
    parameter int BEATS      = TC_WB_BEATS,
    parameter int DATA_W     = TC_MATRIX_BUS_WIDTH,
    parameter int WARP_W     = TC_DEPTH_WARP,
    parameter int FIFO_DEPTH = TC_WB_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [DATA_W-1:0]    in_data_i,
    input  logic [FFLAGS_W-1:0]  in_fflags_i,
    input  logic [REG_IDX_W-1:0] in_reg_idxw_i,
    input  logic [WARP_W-1:0]    in_warpid_i,
    output logic                 wb_valid_o,
    input  logic                 wb_ready_i,
    output logic [DATA_W-1:0]    wb_data_o,
    output logic [REG_IDX_W-1:0] wb_reg_idx_o,
    output logic [WARP_W-1:0]    wb_warpid_o,
    output logic                 wb_last_o,
    output logic [FFLAGS_W-1:0]  wb_fflags_o,
    output logic                 txn_done_o
);

    localparam int CNT_W   = $clog2(BEATS);
    localparam int OCC_W   = $clog2(FIFO_DEPTH + 1);
    localparam int ENTRY_W = DATA_W + REG_IDX_W + WARP_W + 1 + FFLAGS_W;
    localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(BEATS - 1);

    logic [CNT_W-1:0]     beat_cnt;
    logic [REG_IDX_W-1:0] base_idx;
    logic [WARP_W-1:0]    base_warp;
    logic [FFLAGS_W-1:0]  facc;

    logic                 accept;
    logic                 first_beat;
    logic                 last_beat;
    logic [REG_IDX_W-1:0] cur_base;
    logic [REG_IDX_W-1:0] dest_idx;
    logic [WARP_W-1:0]    dest_warp;
    logic [FFLAGS_W-1:0]  push_fflags;
    logic [ENTRY_W-1:0]   push_entry;
    logic [ENTRY_W-1:0]   head_entry;
    logic [OCC_W-1:0]     fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 head_last;
    logic                 wb_pop;

    assign in_ready_o = (fifo_count != OCC_FULL);
    assign accept     = in_valid_i && !fifo_full;
    assign first_beat = (beat_cnt == '0);
    assign last_beat  = (beat_cnt == BEAT_LAST);

    // Beat 0 takes its tags straight from the inputs so it costs no extra cycle.
    assign cur_base    = first_beat ? in_reg_idxw_i : base_idx;
    assign dest_idx    = wb_dest_idx(cur_base, REG_IDX_W'(beat_cnt));
    assign dest_warp   = first_beat ? in_warpid_i : base_warp;
    assign push_fflags = first_beat ? in_fflags_i : (facc | in_fflags_i);
    assign push_entry  = {in_data_i, dest_idx, dest_warp, last_beat, push_fflags};

    assign {wb_data_o, wb_reg_idx_o, wb_warpid_o, head_last, wb_fflags_o} = head_entry;
    assign wb_last_o  = head_last;
    assign wb_valid_o = !fifo_empty;
    assign wb_pop     = wb_valid_o && wb_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt   <= '0;
            base_idx   <= '0;
            base_warp  <= '0;
            facc       <= '0;
            txn_done_o <= 1'b0;
        end else begin
            txn_done_o <= wb_pop && head_last;
            if (accept) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
                facc     <= last_beat ? '0 : push_fflags;
                if (first_beat) begin
                    base_idx  <= in_reg_idxw_i;
                    base_warp <= in_warpid_i;
                end
            end
        end
    end

    tc_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .din   (push_entry),
        .pop   (wb_pop),
        .dout  (head_entry),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: doc/tc_mm_result_wb.md
# tc_mm_result_wb

Writeback collector directly downstream of `tc_mm_add`. It accepts the four 512-bit result beats of one matrix transaction (16 fp32 elements per beat) over a valid/ready handshake. It tags each beat with its destination register index and warp id, and accumulates the exception flags across the transaction. Tagged beats are queued in a small FIFO that drives the register-file writeback port, which can apply backpressure independently.

## Interface
- `BEATS`, default 4: beats per transaction, power of two, at least 2.
- `DATA_W`, default `` `TC_MATRIX_BUS_WIDTH `` (512): beat width.
- `WARP_W`, default `` `TC_DEPTH_WARP ``: warp id width.
- `FIFO_DEPTH`, default 2: output queue entries, power of two, at least 2.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: reset, synchronous, active-high.
- `in_valid_i`  in  1: upstream beat valid.
- `in_ready_o`  out  1: block can accept a beat.
- `in_data_i`  in  DATA_W: result beat.
- `in_fflags_i`  in  5: fflags of this beat.
- `in_reg_idxw_i`  in  8: base destination register.
- `in_warpid_i`  in  WARP_W: warp id.
- `wb_valid_o`  out  1: writeback request valid.
- `wb_ready_i`  in  1: register file accepts the request.
- `wb_data_o`  out  DATA_W: beat data.
- `wb_reg_idx_o`  out  8: destination register.
- `wb_warpid_o`  out  WARP_W: warp id.
- `wb_last_o`  out  1: final beat of the transaction.
- `wb_fflags_o`  out  5: cumulative fflags.
- `txn_done_o`  out  1: one-cycle pulse when a last beat is popped.

## Operation
- A beat is accepted on a `clk` edge where `in_valid_i && in_ready_o`.
- Beat counter `beat_cnt` (log2 BEATS bits):
  - increments on each accepted beat;
  - wraps to 0 after beat BEATS-1;
  - never changes without an accepted beat.
- Beat 0 of a transaction:
  - latches `in_reg_idxw_i` and `in_warpid_i` into base registers;
  - sideband on beats 1..BEATS-1 is ignored.
- Destination register is base + `beat_cnt`, 8-bit modulo 256. Example: base 8'hFE gives FE, FF, 00, 01.
- Beat 0 writes the base directly from the inputs, so beat 0 adds no extra latency.
- Flag accumulator `facc`:
  - the pushed fflags value is `facc | in_fflags_i` (on beat 0, just `in_fflags_i`);
  - `facc` is updated to that value;
  - `facc` clears to 0 when the last beat is pushed.
- Pushed entry contents: {data, reg_idx, warpid, last = (beat_cnt == BEATS-1), fflags}.
- `in_ready_o = (count != FIFO_DEPTH)`, where `count` is registered occupancy. When full, a simultaneous pop does not raise ready in the same cycle.
- Pop occurs on `wb_valid_o && wb_ready_i`; `wb_valid_o = (count != 0)`.
- Simultaneous push and pop when neither full nor empty: `count` stays the same and both pointers advance.
- `txn_done_o` is registered: it is high for one cycle after popping an entry with `last` = 1.

## Timing
- Reset values:
  - `in_ready_o` = 1;
  - `wb_valid_o` = 0;
  - `wb_last_o` = 0;
  - `wb_fflags_o` = 0;
  - `wb_reg_idx_o` = 0;
  - `wb_warpid_o` = 0;
  - `wb_data_o` = 0;
  - `txn_done_o` = 0;
  - internally `beat_cnt` = 0, `facc` = 0, FIFO empty.
- Latency: a beat accepted at edge N is presented on `wb_*` from cycle N+1 (registered FIFO head).
- Throughput: one beat per cycle is sustained when `wb_ready_i` stays high.
- `wb_*` outputs hold stable while `wb_valid_o && !wb_ready_i`.
- `rst` asserted mid-transaction:
  - the partial transaction and all queued entries are discarded;
  - the next accepted beat is treated as beat 0.
- Upstream must not change `in_*` while `in_valid_i && !in_ready_o`. The block does not check this.

## Structure
- `tensor_core_params.svh` gains `` `TC_WB_BEATS `` and `` `TC_WB_FIFO_DEPTH ``, which set the parameter defaults.
- Sub-module `tc_sync_fifo`:
  - generic synchronous FIFO with registered head, parameters WIDTH and DEPTH;
  - registered `count`, full and empty outputs;
  - `tc_mm_result_wb` instantiates it with WIDTH = DATA_W + 8 + WARP_W + 1 + 5.
- Counter, base registers and flag accumulator live in the top module.

## Test plan
- Single transaction:
  - stimulus: base 8'h10, warp 3, `wb_ready_i` = 1, four beats with fflags 1, 0, 4, 0;
  - required: reg idx 10, 11, 12, 13; warp 3 on every beat; fflags 1, 1, 5, 5; `wb_last_o` only on beat 3; `txn_done_o` pulses once.
- Wrap:
  - stimulus: base 8'hFE;
  - required: reg idx FE, FF, 00, 01.
- Sideband ignore:
  - stimulus: beats 1–3 carry reg idx 8'h55 and warp 7;
  - required: outputs keep the beat-0 values.
- Backpressure:
  - stimulus: `wb_ready_i` = 0 for 5 cycles after the first beat;
  - required: `in_ready_o` falls after 2 pushes; `wb_*` holds stable; no beat is lost; order is preserved.
- Back-to-back transactions:
  - stimulus: three transactions, the third with base 8'h20 and fflags 0;
  - required: `facc` restarts for each transaction, so the third's fflags are all 0 with reg idx 20..23; three `txn_done_o` pulses.
- Reset mid-transaction:
  - stimulus: `rst` after beat 1 while 2 entries are queued;
  - required: `wb_valid_o` = 0 the next cycle; the following beat uses the new base as beat 0.
